// File: rtl/msg_loc_queue.sv
//-----------------------------------------------------------------------------
// Module   : msg_loc_queue
// Purpose  : Circular queue of FIX message location descriptors. The
//            tokenizer opens a message with a start offset and closes it
//            with an end offset; each closed message is committed as a
//            {start, end, len} descriptor. Consumers pop descriptors through
//            a valid/ready port and may peek any queued descriptor through a
//            registered random-access lookup port (1-cycle latency).
// Revision : 1.0 - initial release
//
// Ports:
//   clk, rst                    clock (rising edge), async active-high reset
//   open_i, start_i             open a message, capture its start offset
//   close_i, end_i              close the open message, commit descriptor
//   rd_valid_o / rd_ready_i     pop handshake for the head descriptor
//   rd_start_o/end_o/len_o      head descriptor (zero while empty)
//   lookup_i, lookup_idx_i      peek request, offset from head
//   lookup_valid_o/start_o/end_o registered peek result
//   count_o, full_o             occupancy
//   open_o                      a message is currently open
//   overflow_o                  sticky: a commit was dropped (queue full)
//   proto_err_o                 1-cycle pulse: close with no open message
//
// Optional feature: define MSG_LOC_QUEUE_FLUSH_EN to add input flush_i,
// which synchronously empties the queue and clears overflow_o.
//-----------------------------------------------------------------------------
`default_nettype none

module msg_loc_queue #(
   parameter int DATA_WIDTH = 5,
   parameter int DEPTH      = 16,
   parameter int IDX_WIDTH  = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef MSG_LOC_QUEUE_FLUSH_EN
   input  logic                  flush_i,
`endif
   input  logic                  open_i,
   input  logic [DATA_WIDTH-1:0] start_i,
   input  logic                  close_i,
   input  logic [DATA_WIDTH-1:0] end_i,
   output logic                  rd_valid_o,
   input  logic                  rd_ready_i,
   output logic [DATA_WIDTH-1:0] rd_start_o,
   output logic [DATA_WIDTH-1:0] rd_end_o,
   output logic [DATA_WIDTH-1:0] rd_len_o,
   input  logic                  lookup_i,
   input  logic [IDX_WIDTH-1:0]  lookup_idx_i,
   output logic                  lookup_valid_o,
   output logic [DATA_WIDTH-1:0] lookup_start_o,
   output logic [DATA_WIDTH-1:0] lookup_end_o,
   output logic [IDX_WIDTH:0]    count_o,
   output logic                  full_o,
   output logic                  open_o,
   output logic                  overflow_o,
   output logic                  proto_err_o
);

   localparam logic [IDX_WIDTH:0]    C_DEPTH   = (IDX_WIDTH+1)'(DEPTH);
   localparam logic [IDX_WIDTH-1:0]  C_PTR_ONE = IDX_WIDTH'(1);
   localparam logic [IDX_WIDTH:0]    C_CNT_ONE = (IDX_WIDTH+1)'(1);
   localparam logic [DATA_WIDTH-1:0] C_LEN_ONE = DATA_WIDTH'(1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      OPEN = 1'b1
   } state_t;

   state_t state, state_next;

   logic [DATA_WIDTH-1:0] staged_start;
   logic [DATA_WIDTH-1:0] start_mem [DEPTH];
   logic [DATA_WIDTH-1:0] end_mem   [DEPTH];
   logic [DATA_WIDTH-1:0] len_mem   [DEPTH];

   logic [IDX_WIDTH-1:0]  wr_ptr;
   logic [IDX_WIDTH-1:0]  rd_ptr;
   logic [IDX_WIDTH:0]    count;

   logic                  flush;
   logic                  commit_req;
   logic [DATA_WIDTH-1:0] commit_start;
   logic [DATA_WIDTH-1:0] commit_len;
   logic                  load_stage;
   logic                  proto_err_next;
   logic                  pop;
   logic                  commit_ok;
   logic                  lookup_req;
   logic                  lookup_hit;
   logic [IDX_WIDTH-1:0]  lookup_addr;

`ifdef MSG_LOC_QUEUE_FLUSH_EN
   assign flush = flush_i;
`else
   assign flush = 1'b0;
`endif

   //--------------------------------------------------------------------------
   // Write FSM: next state and commit decode. Flush masks every request.
   //--------------------------------------------------------------------------
   always_comb begin
      state_next     = state;
      commit_req     = 1'b0;
      commit_start   = staged_start;
      load_stage     = 1'b0;
      proto_err_next = 1'b0;
      if (flush) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (open_i && close_i) begin
                  // Single-cycle message: start comes straight from the port.
                  commit_req   = 1'b1;
                  commit_start = start_i;
               end else if (open_i) begin
                  load_stage = 1'b1;
                  state_next = OPEN;
               end else if (close_i) begin
                  proto_err_next = 1'b1;
               end
            end
            OPEN: begin
               // Close commits the staged start; a simultaneous open begins
               // the next message, so the FSM stays OPEN.
               commit_req = close_i;
               if (open_i) begin
                  load_stage = 1'b1;
               end else if (close_i) begin
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Offsets live in a circular byte buffer, so length wraps modulo 2^W.
   assign commit_len  = end_i - commit_start + C_LEN_ONE;

   assign pop         = (count != '0) && rd_ready_i && !flush;
   // A full queue still accepts a commit when the head leaves this cycle.
   assign commit_ok   = commit_req && ((count != C_DEPTH) || pop);
   assign lookup_req  = lookup_i && !flush;
   assign lookup_addr = rd_ptr + lookup_idx_i;
   assign lookup_hit  = lookup_req && ({1'b0, lookup_idx_i} < count);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         staged_start <= '0;
      end else if (load_stage) begin
         staged_start <= start_i;
      end
   end

   // Descriptor storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (commit_ok) begin
         start_mem[wr_ptr] <= commit_start;
         end_mem[wr_ptr]   <= end_i;
         len_mem[wr_ptr]   <= commit_len;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         overflow_o     <= 1'b0;
         proto_err_o    <= 1'b0;
         lookup_valid_o <= 1'b0;
         lookup_start_o <= '0;
         lookup_end_o   <= '0;
      end else if (flush) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         overflow_o     <= 1'b0;
         proto_err_o    <= 1'b0;
         lookup_valid_o <= 1'b0;
      end else begin
         proto_err_o    <= proto_err_next;
         lookup_valid_o <= lookup_hit;
         if (commit_ok) begin
            wr_ptr <= wr_ptr + C_PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + C_PTR_ONE;
         end
         if (commit_ok && !pop) begin
            count <= count + C_CNT_ONE;
         end else if (pop && !commit_ok) begin
            count <= count - C_CNT_ONE;
         end
         if (commit_req && !commit_ok) begin
            overflow_o <= 1'b1;
         end
         // Misses hold the previous data; reads see pre-pop contents.
         if (lookup_hit) begin
            lookup_start_o <= start_mem[lookup_addr];
            lookup_end_o   <= end_mem[lookup_addr];
         end
      end
   end

   assign rd_valid_o = (count != '0);
   // Head fields are masked while empty so the unreset memory never leaks.
   assign rd_start_o = rd_valid_o ? start_mem[rd_ptr] : '0;
   assign rd_end_o   = rd_valid_o ? end_mem[rd_ptr]   : '0;
   assign rd_len_o   = rd_valid_o ? len_mem[rd_ptr]   : '0;
   assign count_o    = count;
   assign full_o     = (count == C_DEPTH);
   assign open_o     = (state == OPEN);

endmodule

`default_nettype wire
